// File: rtl/io_pkg.sv
// Shared constants and FSM state encoding for the IN-instruction input controller.
package io_pkg;

  localparam int unsigned DATA_WIDTH          = 32;
  localparam int unsigned SW_WIDTH_DEF        = 16;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;

  typedef logic [1:0] io_state_t;

  localparam io_state_t StIdle        = 2'd0;
  localparam io_state_t StWaitPress   = 2'd1;
  localparam io_state_t StWaitRelease = 2'd2;
  localparam io_state_t StDone        = 2'd3;

endpackage

// File: rtl/io_debouncer.sv
// Two-flop synchronizer plus counter debouncer; emits the clean level and a rise pulse.
module io_debouncer
  import io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic        sync1_q, sync2_q;
  logic        level_q, level_d;
  logic        rise_q, rise_d;
  logic [15:0] cnt_q, cnt_d;

  // Counter only runs while the synchronized input disagrees with the clean level.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == 16'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/io_input_ctrl.sv
// IN-instruction controller: stalls the pipeline until a debounced confirm press captures switches.
// Define IO_INPUT_SIGN_EXT_EN to sign-extend the switch word; default build zero-extends.
module io_input_ctrl
  import io_pkg::*;
#(
  parameter int unsigned SW_WIDTH        = SW_WIDTH_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_req,
  input  logic [SW_WIDTH-1:0]   switches,
  input  logic                  enter_btn,
  output logic [DATA_WIDTH-1:0] data_io,
  output logic                  stall,
  output logic                  in_done
);

  io_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] sw_ext;
  logic                  btn_clean, btn_rise;

  io_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk   (clk),
    .reset (reset),
    .raw   (enter_btn),
    .level (btn_clean),
    .rise  (btn_rise)
  );

`ifdef IO_INPUT_SIGN_EXT_EN
  assign sw_ext = DATA_WIDTH'($signed(switches));
`else
  assign sw_ext = DATA_WIDTH'(switches);
`endif

  // Dropping in_req while waiting is a pipeline flush and takes priority over the button.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      StIdle: if (in_req) state_d = StWaitPress;
      StWaitPress: begin
        if (!in_req) begin
          state_d = StIdle;
        end else if (btn_rise) begin
          data_d  = sw_ext;
          state_d = StWaitRelease;
        end
      end
      StWaitRelease: begin
        if (!in_req) state_d = StIdle;
        else if (!btn_clean) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign data_io = data_q;
  assign in_done = (state_q == StDone);
  assign stall   = ((state_q == StIdle) && in_req) || (state_q == StWaitPress) ||
                   (state_q == StWaitRelease);

endmodule
